idu_issue_ctrl: RTL and testbench
=================================

Name: idu_issue_ctrl

Overview:
- Issue controller and scoreboard for the decode stage; owns the ID-stage valid bit and the IFU→IDU→EXU valid/ready handshakes.
- Tracks in-flight GPR and CSR writes. Holds an instruction in decode while it would read a stale register or CSR, and releases it once writeback clears the hazard.
- Sits between the IFU/IDU pipeline register and the EXU, next to the GPR/CSR register files.

Parameters:
- GPR_NUM, 32, number of architectural GPRs; x0 never marked busy
- GPR_W, 5, GPR index width
- CNT_W, 2, width of per-GPR pending-write counter (max 2^CNT_W-1 in flight per rd)
- CSR_CNT_W, 2, width of in-flight CSR-write counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- IFU_valid  in  1  upstream has an instruction for decode
- IDU_ready  out  1  decode can accept this cycle
- IDU_valid  out  1  decoded instruction is issuable to EXU this cycle
- EXU_ready  in  1  EXU accepts the issued instruction
- flush  in  1  branch/jump redirect; kill the decode-stage instruction
- dec_rs1  in  GPR_W  source 1 index
- dec_rs2  in  GPR_W  source 2 index
- dec_rd  in  GPR_W  destination index
- dec_use_rs1  in  1  instruction reads rs1
- dec_use_rs2  in  1  instruction reads rs2
- dec_write_gpr  in  1  instruction writes rd
- dec_read_csr  in  1  instruction reads a CSR
- dec_write_csr  in  1  instruction writes one or two CSRs (counts as one in-flight entry)
- WB_gpr_clr  in  1  a GPR-writing instruction retired or was killed after issue
- WB_gpr_clr_rd  in  GPR_W  its rd
- WB_csr_clr  in  1  a CSR-writing instruction retired or was killed after issue
- stall_cnt  out  32  saturating count of hazard-stall cycles, for perf

Behaviour:
- Reset (async, immediate):
  - state=EMPTY, IDU_ready=1, IDU_valid=0.
  - All GPR counters, csr_cnt and stall_cnt = 0.
- States:
  - EMPTY: no instruction held; IDU_ready=1.
  - FULL: instruction held, no hazard; IDU_valid=1.
  - BLOCK: instruction held, hazard present; IDU_valid=0.
- hazard (combinational on held fields, current counters):
  - (use_rs1 && rs1!=0 && cnt[rs1]!=0)
  - || (use_rs2 && rs2!=0 && cnt[rs2]!=0)
  - || (write_gpr && rd!=0 && cnt[rd]==max)
  - || (read_csr && csr_cnt!=0)
  - || (write_csr && csr_cnt==max)
- Clears are applied before the hazard evaluation of the same cycle: the WB_* clr inputs bypass into hazard, so a clear can release an instruction with zero added latency.
- issue = IDU_valid && EXU_ready.
- IDU_ready = EMPTY || issue; a full, not-issuing stage back-pressures the IFU.
- Transitions (flush has priority over everything):
  - flush → EMPTY. The held instruction is dropped with no counter update, and IFU_valid in the same cycle is ignored.
  - EMPTY & IFU_valid → FULL or BLOCK, per hazard on the accepted fields next cycle.
  - FULL & issue & IFU_valid → FULL or BLOCK (back-to-back).
  - FULL & issue & !IFU_valid → EMPTY.
  - FULL & !EXU_ready → stays FULL; fields stable.
  - BLOCK → FULL when hazard clears. Otherwise stall_cnt++ each cycle, saturating at 2^32-1.
- Counter updates:
  - On issue with write_gpr && rd!=0: cnt[rd]+1.
  - On WB_gpr_clr with clr_rd!=0: cnt[clr_rd]-1.
  - Same index incremented and decremented in one cycle: net unchanged.
  - csr_cnt follows the same rules with write_csr / WB_csr_clr.
- Wrap/underflow: the hazard check guarantees no increment at max. A decrement at 0 is a protocol error: the counter is held at 0 and an assertion fires in simulation.
- Latency: an instruction accepted in cycle N can issue in cycle N+1 at the earliest. The block holds decoded fields only, never register data.
- Mid-operation reset: everything returns to the reset values asynchronously. The back end is reset by the same rst, so there are no orphan clears.

Decomposition:
- Shared package (the team's existing DEFINES): GPR_W, CNT_W, CSR_CNT_W; the state enum {EMPTY, FULL, BLOCK}.
- One sub-module: idu_gpr_scoreboard. It holds the 32 counters, the inc/dec ports and the busy/full lookup for rs1/rs2/rd, including the clear bypass.

Test Plan:
- Reset, then IFU_valid with rs1=5 and cnt all 0, EXU_ready=1 → IDU_valid=1 next cycle; issue writes rd=5, cnt[5]=1.
- RAW: issue writes x5, next instruction reads rs1=5 → BLOCK and stall_cnt increments. WB_gpr_clr rd=5 in cycle K → IDU_valid=1 in cycle K (bypass) and cnt[5]=0.
- x0: rd=0, then rs1=0 back-to-back → no counter change, no stall.
- Saturation: three issues writing x7 with no clear (CNT_W=2) → a fourth writer to x7 BLOCKs until one WB_gpr_clr rd=7.
- Simultaneous issue of an rd=9 writer and WB_gpr_clr rd=9 with cnt[9]=1 → cnt[9] stays 1.
- flush while in BLOCK with IFU_valid=1 → EMPTY next cycle, IDU_valid=0, counters unchanged. A CSR reader behind csr_cnt=1 stays blocked until WB_csr_clr.

Source files
------------

// File: rtl/idu_issue_ctrl_pkg.sv
// Shared decode-stage definitions: scoreboard widths, issue FSM states and
// the decoded-field bundle held in the ID stage.
package idu_issue_ctrl_pkg;

  localparam int unsigned GPR_NUM   = 32;
  localparam int unsigned GPR_W     = 5;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned CSR_CNT_W = 2;
  localparam int unsigned STALL_W   = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_BLOCK = 2'd2
  } idu_state_e;

  // Decoded fields the issue logic needs; register data is never held here.
  typedef struct packed {
    logic [GPR_W-1:0] rs1;
    logic [GPR_W-1:0] rs2;
    logic [GPR_W-1:0] rd;
    logic             use_rs1;
    logic             use_rs2;
    logic             write_gpr;
    logic             read_csr;
    logic             write_csr;
  } dec_fields_t;

endpackage

// File: rtl/idu_issue_ctrl_gpr_scoreboard.sv
// idu_gpr_scoreboard: per-GPR in-flight write counters.
//   clk, rst              clock, async active-high reset
//   inc_i / inc_rd_i      an instruction writing rd issued
//   dec_i / dec_rd_i      a GPR writer retired or was killed after issue
//   cur_*_i / cur_*_o     lookup for the held instruction, clear bypassed in
//   nxt_*_i / nxt_*_o     lookup for an incoming instruction against the
//                         counter values of the next cycle
module idu_gpr_scoreboard
  import idu_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic [GPR_W-1:0] inc_rd_i,
  input  logic             dec_i,
  input  logic [GPR_W-1:0] dec_rd_i,
  input  logic [GPR_W-1:0] cur_rs1_i,
  input  logic [GPR_W-1:0] cur_rs2_i,
  input  logic [GPR_W-1:0] cur_rd_i,
  input  logic [GPR_W-1:0] nxt_rs1_i,
  input  logic [GPR_W-1:0] nxt_rs2_i,
  input  logic [GPR_W-1:0] nxt_rd_i,
  output logic             cur_rs1_busy_o,
  output logic             cur_rs2_busy_o,
  output logic             cur_rd_full_o,
  output logic             nxt_rs1_busy_o,
  output logic             nxt_rs2_busy_o,
  output logic             nxt_rd_full_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q   [GPR_NUM];
  logic [CNT_W-1:0] cnt_eff [GPR_NUM];
  logic [CNT_W-1:0] cnt_d   [GPR_NUM];

  // cnt_eff has this cycle's clear applied (bypass); cnt_d adds the issue.
  // x0 is never incremented, so its counter stays zero and is never cleared.
  always_comb begin
    for (int unsigned i = 0; i < GPR_NUM; i++) begin
      cnt_eff[i] = cnt_q[i];
      if (dec_i && (dec_rd_i == GPR_W'(i)) && (cnt_q[i] != '0)) begin
        cnt_eff[i] = cnt_q[i] - CNT_W'(1);
      end
      cnt_d[i] = cnt_eff[i];
      if (inc_i && (inc_rd_i == GPR_W'(i)) && (i != 0)) begin
        cnt_d[i] = cnt_eff[i] + CNT_W'(1);
      end
    end
  end

  assign cur_rs1_busy_o = (cur_rs1_i != '0) && (cnt_eff[cur_rs1_i] != '0);
  assign cur_rs2_busy_o = (cur_rs2_i != '0) && (cnt_eff[cur_rs2_i] != '0);
  assign cur_rd_full_o  = (cur_rd_i  != '0) && (cnt_eff[cur_rd_i]  == CNT_MAX);
  assign nxt_rs1_busy_o = (nxt_rs1_i != '0) && (cnt_d[nxt_rs1_i] != '0);
  assign nxt_rs2_busy_o = (nxt_rs2_i != '0) && (cnt_d[nxt_rs2_i] != '0);
  assign nxt_rd_full_o  = (nxt_rd_i  != '0) && (cnt_d[nxt_rd_i]  == CNT_MAX);

  // Counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < GPR_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear of an idle register means the back end lost track of a writer.
  a_no_gpr_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec_i && (dec_rd_i != '0) && (cnt_q[dec_rd_i] == '0)));

endmodule

// File: rtl/idu_issue_ctrl.sv
// idu_issue_ctrl: ID-stage valid bit, IFU->IDU->EXU handshakes and RAW/WAW
// hazard interlock on GPRs and CSRs.
//   clk, rst                     clock, async active-high reset
//   IFU_valid / IDU_ready        upstream handshake
//   IDU_valid / EXU_ready        downstream handshake (issue)
//   flush                        kill the decode-stage instruction
//   dec_*                        decoded fields of the incoming instruction
//   WB_gpr_clr(_rd), WB_csr_clr  writeback/kill clears of in-flight writers
//   stall_cnt                    saturating hazard-stall cycle count
module idu_issue_ctrl
  import idu_issue_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               IFU_valid,
  output logic               IDU_ready,
  output logic               IDU_valid,
  input  logic               EXU_ready,
  input  logic               flush,
  input  logic [GPR_W-1:0]   dec_rs1,
  input  logic [GPR_W-1:0]   dec_rs2,
  input  logic [GPR_W-1:0]   dec_rd,
  input  logic               dec_use_rs1,
  input  logic               dec_use_rs2,
  input  logic               dec_write_gpr,
  input  logic               dec_read_csr,
  input  logic               dec_write_csr,
  input  logic               WB_gpr_clr,
  input  logic [GPR_W-1:0]   WB_gpr_clr_rd,
  input  logic               WB_csr_clr,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [CSR_CNT_W-1:0] CSR_MAX = '1;

  idu_state_e             state_q, state_d;
  dec_fields_t            fld_q, fld_d, dec_in;
  logic [CSR_CNT_W-1:0]   csr_q, csr_eff, csr_d;
  logic [STALL_W-1:0]     stall_q, stall_d;

  logic cur_rs1_busy, cur_rs2_busy, cur_rd_full;
  logic nxt_rs1_busy, nxt_rs2_busy, nxt_rd_full;
  logic held, hazard, nxt_hazard, issue;
  idu_state_e load_state;

  assign dec_in = '{rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd,
                    use_rs1: dec_use_rs1, use_rs2: dec_use_rs2,
                    write_gpr: dec_write_gpr, read_csr: dec_read_csr,
                    write_csr: dec_write_csr};

  idu_gpr_scoreboard u_gpr_sb (
    .clk            (clk),
    .rst            (rst),
    .inc_i          (issue && fld_q.write_gpr),
    .inc_rd_i       (fld_q.rd),
    .dec_i          (WB_gpr_clr),
    .dec_rd_i       (WB_gpr_clr_rd),
    .cur_rs1_i      (fld_q.rs1),
    .cur_rs2_i      (fld_q.rs2),
    .cur_rd_i       (fld_q.rd),
    .nxt_rs1_i      (dec_in.rs1),
    .nxt_rs2_i      (dec_in.rs2),
    .nxt_rd_i       (dec_in.rd),
    .cur_rs1_busy_o (cur_rs1_busy),
    .cur_rs2_busy_o (cur_rs2_busy),
    .cur_rd_full_o  (cur_rd_full),
    .nxt_rs1_busy_o (nxt_rs1_busy),
    .nxt_rs2_busy_o (nxt_rs2_busy),
    .nxt_rd_full_o  (nxt_rd_full)
  );

  // CSR in-flight counter: clear bypassed into the hazard, issue adds one.
  always_comb begin
    csr_eff = csr_q;
    if (WB_csr_clr && (csr_q != '0)) begin
      csr_eff = csr_q - CSR_CNT_W'(1);
    end
    csr_d = csr_eff;
    if (issue && fld_q.write_csr) begin
      csr_d = csr_eff + CSR_CNT_W'(1);
    end
  end

  // Hazard of the held instruction, with this cycle's clears already applied.
  assign hazard = (fld_q.use_rs1   && cur_rs1_busy)
               || (fld_q.use_rs2   && cur_rs2_busy)
               || (fld_q.write_gpr && cur_rd_full)
               || (fld_q.read_csr  && (csr_eff != '0))
               || (fld_q.write_csr && (csr_eff == CSR_MAX));

  // Hazard an incoming instruction will see once it is held next cycle.
  assign nxt_hazard = (dec_in.use_rs1   && nxt_rs1_busy)
                   || (dec_in.use_rs2   && nxt_rs2_busy)
                   || (dec_in.write_gpr && nxt_rd_full)
                   || (dec_in.read_csr  && (csr_d != '0))
                   || (dec_in.write_csr && (csr_d == CSR_MAX));

  assign load_state = nxt_hazard ? ST_BLOCK : ST_FULL;
  assign held       = (state_q != ST_EMPTY);

  // A flushed instruction must not handshake with the EXU.
  assign IDU_valid = held && !hazard && !flush;
  assign issue     = IDU_valid && EXU_ready;
  assign IDU_ready = (state_q == ST_EMPTY) || issue;
  assign stall_cnt = stall_q;

  // Next state, held fields and stall counter.
  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    stall_d = stall_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (IFU_valid) begin
            fld_d   = dec_in;
            state_d = load_state;
          end
        end
        ST_FULL, ST_BLOCK: begin
          if (issue) begin
            if (IFU_valid) begin
              fld_d   = dec_in;
              state_d = load_state;
            end else begin
              state_d = ST_EMPTY;
            end
          end else if (hazard) begin
            state_d = ST_BLOCK;
            if (stall_q != '1) begin
              stall_d = stall_q + STALL_W'(1);
            end
          end else begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      fld_q   <= '0;
      csr_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      csr_q   <= csr_d;
      stall_q <= stall_d;
    end
  end

  a_no_csr_underflow: assert property (@(posedge clk) disable iff (rst)
    !(WB_csr_clr && (csr_q == '0)));

endmodule

// File: tb/tb_idu_issue_ctrl.sv
// Directed bench for idu_issue_ctrl: each stimulus cycle queues the expected
// IDU_valid / IDU_ready / stall_cnt; a monitor compares on the falling edge.
module tb_idu_issue_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       wg;
    logic       rc;
    logic       wc;
  } tdec_t;

  typedef struct {
    int unsigned cyc;
    logic        vld;
    logic        rdy;
    logic [31:0] stall;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IFU_valid = 1'b0;
  logic        EXU_ready = 1'b0;
  logic        flush = 1'b0;
  logic        WB_gpr_clr = 1'b0;
  logic [4:0]  WB_gpr_clr_rd = '0;
  logic        WB_csr_clr = 1'b0;
  tdec_t       dec = '0;
  logic        IDU_ready;
  logic        IDU_valid;
  logic [31:0] stall_cnt;

  int unsigned cyc = 0;
  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  idu_issue_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .IFU_valid     (IFU_valid),
    .IDU_ready     (IDU_ready),
    .IDU_valid     (IDU_valid),
    .EXU_ready     (EXU_ready),
    .flush         (flush),
    .dec_rs1       (dec.rs1),
    .dec_rs2       (dec.rs2),
    .dec_rd        (dec.rd),
    .dec_use_rs1   (dec.u1),
    .dec_use_rs2   (dec.u2),
    .dec_write_gpr (dec.wg),
    .dec_read_csr  (dec.rc),
    .dec_write_csr (dec.wc),
    .WB_gpr_clr    (WB_gpr_clr),
    .WB_gpr_clr_rd (WB_gpr_clr_rd),
    .WB_csr_clr    (WB_csr_clr),
    .stall_cnt     (stall_cnt)
  );

  function automatic tdec_t mk(input int rs1, input int rs2, input int rd,
                               input bit u1, input bit u2, input bit wg,
                               input bit rc, input bit wc);
    tdec_t d;
    d.rs1 = 5'(rs1);
    d.rs2 = 5'(rs2);
    d.rd  = 5'(rd);
    d.u1  = u1;
    d.u2  = u2;
    d.wg  = wg;
    d.rc  = rc;
    d.wc  = wc;
    return d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.cyc != cyc) begin
        chk({e.nm, ".missed"}, cyc, e.cyc);
      end else begin
        chk({e.nm, ".IDU_valid"}, 32'(IDU_valid), 32'(e.vld));
        chk({e.nm, ".IDU_ready"}, 32'(IDU_ready), 32'(e.rdy));
        chk({e.nm, ".stall_cnt"}, stall_cnt, e.stall);
      end
    end
  end

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input logic r, input logic ifu, input logic exu, input logic fl,
                      input tdec_t d, input logic gclr, input int grd, input logic cclr,
                      input logic ev, input logic er, input int unsigned es,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    IFU_valid     = ifu;
    EXU_ready     = exu;
    flush         = fl;
    dec           = d;
    WB_gpr_clr    = gclr;
    WB_gpr_clr_rd = 5'(grd);
    WB_csr_clr    = cclr;
    e.cyc   = cyc;
    e.vld   = ev;
    e.rdy   = er;
    e.stall = es;
    e.nm    = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    tdec_t n, a, b, c, d0, e0, w7, r7, x9, r9, cw, cr, w3, w4, r3;
    n  = '0;
    a  = mk(5, 0, 5, 1, 0, 1, 0, 0);
    b  = mk(5, 0, 0, 1, 0, 0, 0, 0);
    c  = mk(5, 5, 0, 1, 1, 0, 0, 0);
    d0 = mk(0, 0, 0, 1, 0, 1, 0, 0);
    e0 = mk(0, 0, 0, 1, 1, 1, 0, 0);
    w7 = mk(0, 0, 7, 0, 0, 1, 0, 0);
    r7 = mk(7, 0, 0, 1, 0, 0, 0, 0);
    x9 = mk(0, 0, 9, 0, 0, 1, 0, 0);
    r9 = mk(9, 0, 0, 1, 0, 0, 0, 0);
    cw = mk(0, 0, 0, 0, 0, 0, 0, 1);
    cr = mk(0, 0, 0, 0, 0, 0, 1, 0);
    w3 = mk(0, 0, 3, 0, 0, 1, 0, 0);
    w4 = mk(0, 0, 4, 0, 0, 1, 0, 0);
    r3 = mk(3, 0, 0, 1, 0, 0, 0, 0);

    //    rst ifu exu fl dec  gclr rd cclr  vld rdy stall name
    step(1, 0, 0, 0, n,  0, 0, 0,   0, 1, 0, "reset");
    // first instruction and back-to-back RAW on x5
    step(0, 1, 1, 0, a,  0, 0, 0,   0, 1, 0, "acceptA");
    step(0, 1, 1, 0, b,  0, 0, 0,   1, 1, 0, "issueA");
    step(0, 0, 1, 0, n,  0, 0, 0,   0, 0, 0, "raw_block");
    step(0, 0, 1, 0, n,  0, 0, 0,   0, 0, 1, "raw_stall");
    step(0, 0, 1, 0, n,  1, 5, 0,   1, 1, 2, "raw_bypass");
    step(0, 1, 1, 0, c,  0, 0, 0,   0, 1, 2, "acceptC");
    // x0 never busy
    step(0, 1, 1, 0, d0, 0, 0, 0,   1, 1, 2, "cnt5_zero");
    step(0, 1, 1, 0, e0, 0, 0, 0,   1, 1, 2, "x0_write");
    step(0, 0, 1, 0, n,  0, 0, 0,   1, 1, 2, "x0_read");
    // x7 counter saturation
    step(0, 1, 1, 0, w7, 0, 0, 0,   0, 1, 2, "acceptW7");
    step(0, 1, 1, 0, w7, 0, 0, 0,   1, 1, 2, "w7_1");
    step(0, 1, 1, 0, w7, 0, 0, 0,   1, 1, 2, "w7_2");
    step(0, 1, 1, 0, w7, 0, 0, 0,   1, 1, 2, "w7_3");
    step(0, 0, 1, 0, n,  0, 0, 0,   0, 0, 2, "w7_4_full");
    step(0, 0, 1, 0, n,  1, 7, 0,   1, 1, 3, "w7_4_release");
    step(0, 1, 1, 0, r7, 0, 0, 0,   0, 1, 3, "acceptR7");
    step(0, 0, 1, 0, n,  1, 7, 0,   0, 0, 3, "r7_cnt3");
    step(0, 0, 1, 0, n,  1, 7, 0,   0, 0, 4, "r7_cnt2");
    step(0, 0, 1, 0, n,  1, 7, 0,   1, 1, 5, "r7_release");
    // simultaneous inc/dec of x9
    step(0, 1, 1, 0, x9, 0, 0, 0,   0, 1, 5, "acceptX9");
    step(0, 1, 1, 0, x9, 0, 0, 0,   1, 1, 5, "x9_first");
    step(0, 1, 1, 0, r9, 1, 9, 0,   1, 1, 5, "x9_inc_dec");
    step(0, 0, 1, 0, n,  0, 0, 0,   0, 0, 5, "cnt9_stays1");
    step(0, 0, 1, 0, n,  1, 9, 0,   1, 1, 6, "r9_release");
    // CSR hazard and flush from BLOCK
    step(0, 1, 1, 0, cw, 0, 0, 0,   0, 1, 6, "acceptCW");
    step(0, 1, 1, 0, cr, 0, 0, 0,   1, 1, 6, "issueCW");
    step(0, 0, 1, 0, n,  0, 0, 0,   0, 0, 6, "csr_block");
    step(0, 1, 1, 1, x9, 0, 0, 0,   0, 0, 7, "flush");
    step(0, 0, 1, 0, n,  0, 0, 0,   0, 1, 7, "flush_empty");
    step(0, 1, 1, 0, cr, 0, 0, 0,   0, 1, 7, "acceptCR");
    step(0, 0, 1, 0, n,  0, 0, 0,   0, 0, 7, "csr_held1");
    step(0, 0, 1, 0, n,  0, 0, 0,   0, 0, 8, "csr_held2");
    step(0, 0, 1, 0, n,  0, 0, 1,   1, 1, 9, "csr_release");
    step(0, 1, 1, 0, r9, 0, 0, 0,   0, 1, 9, "acceptR9");
    step(0, 0, 1, 0, n,  0, 0, 0,   1, 1, 9, "flushed_x9_uncounted");
    // EXU back-pressure keeps the held fields
    step(0, 1, 1, 0, w3, 0, 0, 0,   0, 1, 9, "acceptW3");
    step(0, 1, 0, 0, w4, 0, 0, 0,   1, 0, 9, "exu_backpressure");
    step(0, 0, 1, 0, n,  0, 0, 0,   1, 1, 9, "issueW3");
    step(0, 1, 1, 0, r3, 0, 0, 0,   0, 1, 9, "acceptR3");
    step(0, 0, 1, 0, n,  0, 0, 0,   0, 0, 9, "r3_block");
    step(0, 0, 1, 0, n,  1, 3, 0,   1, 1, 10, "r3_release");
    step(0, 0, 1, 0, n,  0, 0, 0,   0, 1, 10, "idle");

    repeat (3) @(posedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.nm, ".never_checked"}, cyc, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
